// File: rtl/ctrl_pkg.sv
// Shared control definitions for the PC/trap sequencer: FSM state encoding
// and the default sequential step and trap-vector constants.
package ctrl_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } seq_state_t;

  localparam int DEF_STEP     = 4;
  localparam int DEF_TRAP_VEC = 'hF0;

endpackage

// File: rtl/irq_latch.sv
// Interrupt pending latch: a rising edge of the request sets a sticky
// pending bit that is held until the sequencer enters the trap.
module irq_latch (
  input  logic clock,
  input  logic reset,
  input  logic interrupt,
  input  logic clear,
  output logic pending
);

  logic interrupt_d;

  // Edge-detect the raw request and hold it until trap entry clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      interrupt_d <= 1'b0;
      pending     <= 1'b0;
    end else begin
      interrupt_d <= interrupt;
      pending     <= (interrupt & ~interrupt_d) | (pending & ~clear);
    end
  end

endmodule

// File: rtl/pc_trap_sequencer.sv
// PC sequencer with single-level trap entry/return, jump-and-link, branch,
// busy stall and a saturating stall counter.
// Optional build macro IRQ_PENDING_LATCH_EN: interrupt edges are latched as
// a pending request instead of being level-sampled.
//
// state | meaning
// RUN   | fetching, PC advances or redirects every cycle
// STALL | memory busy, PC and trap/link status frozen
module pc_trap_sequencer
  import ctrl_pkg::*;
#(
  parameter int               NBITS    = 8,
  parameter int               STEP     = DEF_STEP,
  parameter logic [NBITS-1:0] TRAP_VEC = NBITS'(DEF_TRAP_VEC),
  parameter int               CNT_BITS = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                busy,
  input  logic                interrupt,
  input  logic                branch,
  input  logic                jump,
  input  logic                sret,
  input  logic [NBITS-1:0]    target,
  output logic [NBITS-1:0]    pc,
  output logic [NBITS-1:0]    pc_next,
  output logic [NBITS-1:0]    pclink,
  output logic                link,
  output logic [NBITS-1:0]    sepc,
  output logic                in_trap,
  output logic                int_ack,
  output logic [CNT_BITS-1:0] stall_cnt
);

  seq_state_t       state;
  logic             irq_req;
  logic             take_trap;
  logic             take_sret;
  logic [NBITS-1:0] pc_seq;

  assign pc_seq = pc + NBITS'(STEP);

`ifdef IRQ_PENDING_LATCH_EN
  irq_latch u_irq_latch (
    .clock     (clock),
    .reset     (reset),
    .interrupt (interrupt),
    .clear     (take_trap),
    .pending   (irq_req)
  );
`else
  assign irq_req = interrupt;
`endif

  // Redirect decode: trap beats sret beats jump beats branch; nothing while busy.
  always_comb begin
    take_trap = !busy && irq_req && !in_trap;
    take_sret = !busy && !take_trap && sret && in_trap;
    pc_next   = pc_seq;
    if (!reset)              pc_next = '0;
    else if (busy)           pc_next = pc;
    else if (take_trap)      pc_next = TRAP_VEC;
    else if (take_sret)      pc_next = sepc;
    else if (jump || branch) pc_next = target;
  end

  // Run/stall FSM plus PC, trap status, link and stall counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      pc        <= '0;
      sepc      <= '0;
      pclink    <= '0;
      link      <= 1'b0;
      in_trap   <= 1'b0;
      int_ack   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      pc <= pc_next;
      case (state)
        RUN:   if (busy)  state <= STALL;
        STALL: if (!busy) state <= RUN;
      endcase
      if (busy) begin
        if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_BITS'(1);
      end else begin
        int_ack <= take_trap;
        link    <= !take_trap && !take_sret && jump;
        pclink  <= pc_seq;
        if (take_trap) begin
          sepc    <= pc_seq;
          in_trap <= 1'b1;
        end else if (take_sret) begin
          in_trap <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_trap_sequencer.sv
// Self-checking bench for pc_trap_sequencer (default parameters).
module tb_pc_trap_sequencer;

`ifdef IRQ_PENDING_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        busy = 1'b0, interrupt = 1'b0, branch = 1'b0, jump = 1'b0, sret = 1'b0;
  logic [7:0]  target = '0;
  logic [7:0]  pc, pc_next, pclink, sepc;
  logic        link, in_trap, int_ack;
  logic [15:0] stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  pc_trap_sequencer dut (
    .clock(clock), .reset(reset), .busy(busy), .interrupt(interrupt),
    .branch(branch), .jump(jump), .sret(sret), .target(target),
    .pc(pc), .pc_next(pc_next), .pclink(pclink), .link(link), .sepc(sepc),
    .in_trap(in_trap), .int_ack(int_ack), .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model state (architectural view) and its next values
  logic [7:0]  m_pc, m_sepc, m_pclink, m_nxt;
  logic [15:0] m_cnt;
  bit          m_in_trap, m_int_ack, m_link, m_pend, m_irq_prev;
  logic [7:0]  n_sepc, n_pclink;
  logic [15:0] n_cnt;
  bit          n_in_trap, n_int_ack, n_link, n_pend;

  task automatic model_reset();
    m_pc = 0; m_sepc = 0; m_pclink = 0; m_cnt = 0; m_nxt = 0;
    m_in_trap = 0; m_int_ack = 0; m_link = 0; m_pend = 0; m_irq_prev = 0;
  endtask

  // Drive one cycle of inputs and work out what the spec says should happen.
  task automatic apply(input bit b, input bit irq, input bit br, input bit j,
                       input bit s, input int t);
    bit req, take, ret;
    int seqpc;
    busy = b; interrupt = irq; branch = br; jump = j; sret = s; target = t[7:0];
    #1;
    seqpc = (int'(m_pc) + 4) % 256;
    req   = LATCH ? m_pend : irq;
    take  = !b && req && !m_in_trap;
    ret   = !b && !take && s && m_in_trap;
    if (b)            m_nxt = m_pc;
    else if (take)    m_nxt = 8'hF0;
    else if (ret)     m_nxt = m_sepc;
    else if (j || br) m_nxt = t[7:0];
    else              m_nxt = seqpc[7:0];
    n_cnt     = (b && m_cnt != 16'hFFFF) ? m_cnt + 16'd1 : m_cnt;
    n_sepc    = (take) ? seqpc[7:0] : m_sepc;
    n_in_trap = take ? 1'b1 : (ret ? 1'b0 : m_in_trap);
    n_int_ack = b ? m_int_ack : take;
    n_link    = b ? m_link : (!take && !ret && j);
    n_pclink  = b ? m_pclink : seqpc[7:0];
    n_pend    = (irq && !m_irq_prev) || (m_pend && !take);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    m_pc = m_nxt; m_cnt = n_cnt; m_sepc = n_sepc; m_in_trap = n_in_trap;
    m_int_ack = n_int_ack; m_link = n_link; m_pclink = n_pclink;
    m_pend = n_pend; m_irq_prev = interrupt;
  endtask

  task automatic hold_reset();
    busy = 0; interrupt = 0; branch = 0; jump = 0; sret = 0; target = 0;
    reset = 0;
    #1;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1;
  endtask

  task automatic enter_trap();
    for (int k = 0; k < 4 && !m_in_trap; k++) begin
      apply(0, 1, 0, 0, 0, 0);
      tick();
    end
    vectors++; if (in_trap !== 1'b1) begin miscompares++; $display("FAIL enter_trap in_trap got %0b want 1", in_trap); end
  endtask

  task automatic test_reset();
    reset = 0; interrupt = 1; jump = 1; target = 8'h55;
    #2;
    vectors++; if (pc_next !== 8'h00) begin miscompares++; $display("FAIL rst_pc_next got %h want 00", pc_next); end
    vectors++; if (pc !== 8'h00 || sepc !== 8'h00) begin miscompares++; $display("FAIL rst_pc_sepc got %h/%h want 00/00", pc, sepc); end
    vectors++; if ({in_trap, int_ack, link} !== 3'b000) begin miscompares++; $display("FAIL rst_flags got %b want 000", {in_trap, int_ack, link}); end
    vectors++; if (stall_cnt !== 16'h0) begin miscompares++; $display("FAIL rst_stall_cnt got %h want 0", stall_cnt); end
    @(posedge clock); #1;
    vectors++; if (pc !== 8'h00) begin miscompares++; $display("FAIL rst_pc_hold got %h want 00", pc); end
    hold_reset();
  endtask

  task automatic test_sequential();
    hold_reset();
    for (int k = 1; k <= 4; k++) begin
      apply(0, 0, 0, 0, 0, 0);
      vectors++; if (pc_next !== 8'(4 * k)) begin miscompares++; $display("FAIL seq_pc_next[%0d] got %h want %h", k, pc_next, 8'(4 * k)); end
      tick();
    end
  endtask

  task automatic test_jump_branch();
    hold_reset();
    apply(0, 0, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 1, 0, 'h20);
    vectors++; if (pc_next !== 8'h20) begin miscompares++; $display("FAIL jump_pc_next got %h want 20", pc_next); end
    tick();
    vectors++; if (link !== 1'b1 || pclink !== 8'h0C) begin miscompares++; $display("FAIL jump_link got %b/%h want 1/0c", link, pclink); end
    apply(0, 0, 1, 0, 0, 'h33);
    vectors++; if (pc_next !== 8'h33) begin miscompares++; $display("FAIL branch_pc_next got %h want 33", pc_next); end
    tick();
    vectors++; if (link !== 1'b0 || pc !== 8'h33) begin miscompares++; $display("FAIL branch_link got %b/%h want 0/33", link, pc); end
  endtask

  task automatic test_trap();
    hold_reset();
    for (int k = 0; k < 4; k++) begin apply(0, 0, 0, 0, 0, 0); tick(); end
    // sret outside a trap is just a sequential step
    apply(0, 0, 0, 0, 1, 0);
    vectors++; if (pc_next !== 8'h14) begin miscompares++; $display("FAIL sret_ignored got %h want 14", pc_next); end
    if (!LATCH) begin
      apply(0, 1, 0, 1, 0, 'h77);
      vectors++; if (pc_next !== 8'hF0) begin miscompares++; $display("FAIL trap_pc_next got %h want f0", pc_next); end
      tick();
      vectors++; if (sepc !== 8'h14 || int_ack !== 1'b1 || in_trap !== 1'b1 || link !== 1'b0) begin
        miscompares++; $display("FAIL trap_entry got sepc=%h ack=%b trap=%b link=%b want 14/1/1/0", sepc, int_ack, in_trap, link); end
    end else begin
      enter_trap();
    end
    apply(0, 0, 0, 0, 0, 0);
    tick();
    vectors++; if (int_ack !== 1'b0) begin miscompares++; $display("FAIL int_ack_pulse got %b want 0", int_ack); end
    apply(0, 0, 0, 1, 1, 'h40);
    vectors++; if (pc_next !== m_sepc) begin miscompares++; $display("FAIL sret_pc_next got %h want %h", pc_next, m_sepc); end
    tick();
    vectors++; if (in_trap !== 1'b0 || link !== 1'b0) begin miscompares++; $display("FAIL sret_exit got %b/%b want 0/0", in_trap, link); end
  endtask

  task automatic test_busy();
    hold_reset();
    apply(0, 0, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 0, 0); tick();
    for (int k = 0; k < 3; k++) begin
      apply(1, 1, 0, 1, 0, 'h99);
      vectors++; if (pc_next !== 8'h08) begin miscompares++; $display("FAIL busy_pc_next[%0d] got %h want 08", k, pc_next); end
      tick();
    end
    vectors++; if (stall_cnt !== 16'd3 || pc !== 8'h08 || in_trap !== 1'b0) begin
      miscompares++; $display("FAIL busy_hold got cnt=%0d pc=%h trap=%b want 3/08/0", stall_cnt, pc, in_trap); end
    apply(0, 1, 0, 0, 0, 0);
    vectors++; if (pc_next !== 8'hF0) begin miscompares++; $display("FAIL busy_then_trap got %h want f0", pc_next); end
    tick();
    vectors++; if (int_ack !== 1'b1 || sepc !== 8'h0C) begin miscompares++; $display("FAIL busy_trap_ack got %b/%h want 1/0c", int_ack, sepc); end
    // busy right after entry: trap status frozen
    apply(1, 0, 0, 0, 1, 0);
    vectors++; if (pc_next !== 8'hF0) begin miscompares++; $display("FAIL busy_in_trap got %h want f0", pc_next); end
    tick();
    vectors++; if (in_trap !== 1'b1 || stall_cnt !== 16'd4) begin miscompares++; $display("FAIL busy_sret_blocked got %b/%0d want 1/4", in_trap, stall_cnt); end
  endtask

  task automatic test_wrap();
    hold_reset();
    apply(0, 0, 1, 0, 0, 'hFC); tick();
    apply(0, 0, 0, 0, 0, 0);
    vectors++; if (pc_next !== 8'h00) begin miscompares++; $display("FAIL wrap_pc_next got %h want 00", pc_next); end
    apply(0, 0, 0, 1, 0, 'h40);
    tick();
    vectors++; if (pclink !== 8'h00 || link !== 1'b1) begin miscompares++; $display("FAIL wrap_pclink got %h/%b want 00/1", pclink, link); end
  endtask

  task automatic test_nesting();
    logic [7:0] ret_pc, want;
    hold_reset();
    enter_trap();
    apply(0, 0, 0, 0, 0, 0); tick();
    apply(0, 1, 0, 0, 0, 0);
    vectors++; if (pc_next === 8'hF0 || pc_next !== m_nxt) begin miscompares++; $display("FAIL nest_pc_next got %h want %h", pc_next, m_nxt); end
    tick();
    vectors++; if (int_ack !== 1'b0 || in_trap !== 1'b1) begin miscompares++; $display("FAIL nest_no_ack got %b/%b want 0/1", int_ack, in_trap); end
    ret_pc = m_sepc;
    apply(0, 0, 0, 0, 1, 0);
    vectors++; if (pc_next !== ret_pc) begin miscompares++; $display("FAIL nest_sret got %h want %h", pc_next, ret_pc); end
    tick();
    want = LATCH ? 8'hF0 : ret_pc + 8'd4;
    apply(0, 0, 0, 0, 0, 0);
    vectors++; if (pc_next !== want) begin miscompares++; $display("FAIL nest_after_ret got %h want %h", pc_next, want); end
    tick();
    // interrupt and sret together inside a trap: return first, trap next
    if (!m_in_trap) enter_trap();
    apply(0, 1, 0, 0, 0, 0); tick();
    ret_pc = m_sepc;
    apply(0, 1, 0, 0, 1, 0);
    vectors++; if (pc_next !== ret_pc) begin miscompares++; $display("FAIL irq_sret_ret got %h want %h", pc_next, ret_pc); end
    tick();
    apply(0, 1, 0, 0, 0, 0);
    want = LATCH ? ret_pc + 8'd4 : 8'hF0;
    vectors++; if (pc_next !== want) begin miscompares++; $display("FAIL irq_sret_retrap got %h want %h", pc_next, want); end
    tick();
  endtask

  task automatic test_reset_mid();
    hold_reset();
    enter_trap();
    apply(1, 0, 0, 0, 0, 0); tick();
    #2;
    reset = 0;
    #1;
    vectors++; if (pc !== 8'h00 || pc_next !== 8'h00 || in_trap !== 1'b0 || stall_cnt !== 16'd0 || sepc !== 8'h00) begin
      miscompares++; $display("FAIL mid_reset got pc=%h nxt=%h trap=%b cnt=%0d sepc=%h want all 0", pc, pc_next, in_trap, stall_cnt, sepc); end
    model_reset();
    busy = 0;
    @(posedge clock); #1;
    reset = 1;
    apply(0, 0, 0, 0, 0, 0);
    vectors++; if (pc_next !== 8'h04) begin miscompares++; $display("FAIL mid_reset_resume got %h want 04", pc_next); end
    tick();
    vectors++; if (in_trap !== 1'b0 || pc !== 8'h04) begin miscompares++; $display("FAIL mid_reset_state got %b/%h want 0/04", in_trap, pc); end
  endtask

  task automatic test_random();
    bit irq_level;
    hold_reset();
    irq_level = 0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) == 0) irq_level = !irq_level;
      apply($urandom_range(0, 3) == 0, irq_level, $urandom_range(0, 5) == 0,
            $urandom_range(0, 6) == 0, $urandom_range(0, 3) == 0, int'($urandom_range(0, 255)));
      vectors++; if (pc_next !== m_nxt) begin miscompares++; $display("FAIL rnd_pc_next[%0d] got %h want %h", k, pc_next, m_nxt); end
      tick();
      vectors++;
      if (pc !== m_pc || sepc !== m_sepc || in_trap !== m_in_trap || int_ack !== m_int_ack ||
          link !== m_link || stall_cnt !== m_cnt || (m_link && pclink !== m_pclink)) begin
        miscompares++;
        $display("FAIL rnd_state[%0d] got pc=%h sepc=%h trap=%b ack=%b link=%b lk=%h cnt=%0d want %h %h %b %b %b %h %0d",
                 k, pc, sepc, in_trap, int_ack, link, pclink, stall_cnt,
                 m_pc, m_sepc, m_in_trap, m_int_ack, m_link, m_pclink, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump_branch();
    test_trap();
    test_busy();
    test_wrap();
    test_nesting();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
